instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read port: owns the PC, drives the word address
//  into the combinational instruction memory, captures the returned big-endian word and
//  queues {pc, instr} for decode behind a valid/ready handshake. Handles branch redirects
//  (flush + retarget) and raises a sticky fault on a misaligned target.
// PARAMETERS
//  START_ADDR  32'h8002_0000  PC value after reset; base of instruction memory
//  MEM_BYTES   1024           instruction memory size in bytes (bounds check only)
//  QDEPTH      2              fetch queue entries (power of 2, >=2)
// PORTS
//  clock            in   1   single clock, all state on rising edge
//  reset_n          in   1   synchronous, active-low reset
//  imem_address     out  32  byte address to instruction memory (= pc register)
//  imem_data        in   32  instruction word, valid same cycle as imem_address
//  redirect_valid   in   1   branch/jump taken this cycle
//  redirect_target  in   32  new PC when redirect_valid
//  out_valid        out  1   queue head holds an instruction
//  out_ready        in   1   decode accepts head this cycle
//  out_instr        out  32  head instruction word
//  out_pc           out  32  byte address the head instruction was fetched from
//  fault            out  1   sticky fetch fault; cleared only by reset
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): pc=START_ADDR, queue count=0, state=IDLE, fault=0;
//    out_valid=0, out_instr=0, out_pc=0 while queue empty.
//  - FSM: IDLE -> RUN unconditionally next cycle (one bubble). RUN -> FAULT on fault cond.
//    FAULT: no pushes, queue flushed, out_valid=0, fault=1, redirects ignored; exit by reset.
//  - imem_address = pc register always (no combinational path from redirect inputs).
//  - pop = out_valid & out_ready. push (RUN only) = !redirect_valid & (count<QDEPTH | pop).
//    push writes {pc, imem_data}; pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//  - Latency: instruction at pc appears on out_* the cycle after pc is driven.
//  - Full with no pop: pc holds, imem_address stable, no push.
//  - Simultaneous push+pop when full: legal, count unchanged, throughput 1/cycle.
//  - redirect_valid in RUN: same-cycle pop is accepted, then whole queue flushed (count=0);
//    no push; pc <= redirect_target. Next cycle out_valid=0; target instr valid cycle after.
//  - redirect_target[1:0]!=0: enter FAULT next cycle, pc <= target (for debug), queue flushed.
//  - redirect_valid in IDLE: pc <= target (alignment checked identically), state -> RUN.
//  - Reset mid-operation overrides every other event in that cycle.
// CONFIGURATION
//  FETCH_BOUNDS_CHECK_EN defined: in RUN, pc outside [START_ADDR, START_ADDR+MEM_BYTES)
//    at a would-be push suppresses the push and enters FAULT next cycle.
//  Undefined: no range check; out-of-range pc fetches whatever imem_data returns.
// STRUCTURE
//  fetch_pkg: INSTR_W=32, ADDR_W=32, default START_ADDR, fetch FSM state encoding
//    (IDLE/RUN/FAULT), fetch queue entry type {pc[31:0], instr[31:0]}.
//  Sub-module fetch_queue: QDEPTH-entry sync FIFO (push, pop, flush, count, head);
//    instr_fetch_unit holds pc, FSM, fault and handshake logic.
// TESTING
//  1 Reset, out_ready=1, imem model returns addr^32'hA5A5_0000 -> first out_valid 2 cycles
//    after reset release, out_pc=32'h8002_0000, then 8002_0004, 8002_0008 one per cycle.
//  2 out_ready=0 for 5 cycles -> count saturates at 2, imem_address stays 8002_0008,
//    out_pc holds 8002_0000; on release sequence resumes with no gap/dup.
//  3 Redirect to 32'h8002_0100 while full and out_ready=1 -> next cycle out_valid=0,
//    following cycle out_pc=8002_0100; no stale pc 8002_000x emitted after flush.
//  4 Redirect to 32'h8002_0102 -> fault=1 next cycle, out_valid=0; further redirects
//    ignored; reset_n=0 clears fault and pc=8002_0000.
//  5 Redirect to 32'hFFFF_FFFC, out_ready=1 (macro undefined) -> out_pc FFFF_FFFC then 0.
//  6 FETCH_BOUNDS_CHECK_EN: run to pc=8002_0400 -> last out_pc=8002_03FC, then fault=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, fetch FSM encoding and fetch queue entry type
package fetch_pkg;

   localparam int          INSTR_W            = 32;
   localparam int          ADDR_W             = 32;
   localparam logic [31:0] DEFAULT_START_ADDR = 32'h8002_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry synchronous fetch FIFO with flush and head view
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   // Entry storage: a flush discards any push made in the same cycle.
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking; flush empties the queue outright.
   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch queue front end; optional FETCH_BOUNDS_CHECK_EN
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
   parameter int          MEM_BYTES  = 1024,
   parameter int          QDEPTH     = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic [ADDR_W-1:0]  imem_address,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               fault
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [CW-1:0]     count;
   fetch_entry_t      head;
   fetch_entry_t      push_data;
   logic              push, pop, flush;
   logic              misaligned;
   logic              has_room;
   logic              bounds_fail;

   assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign has_room   = (count < CW'(QDEPTH)) || pop;
   assign pop        = out_valid && out_ready;
   assign push_data  = '{pc: pc, instr: imem_data};

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [32:0] WIN_LO = {1'b0, START_ADDR};
   localparam logic [32:0] WIN_HI = {1'b0, START_ADDR} + 33'(MEM_BYTES);
   assign bounds_fail = ({1'b0, pc} < WIN_LO) || ({1'b0, pc} >= WIN_HI);
`else
   assign bounds_fail = 1'b0;
`endif

   // State and PC registers; reset beats every other event in the cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         pc    <= START_ADDR;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // Next-state, PC update and queue control for the fetch FSM.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      push       = 1'b0;
      flush      = 1'b0;
      case (state)
         ST_IDLE: begin
            state_next = ST_RUN;
            if (redirect_valid) begin
               pc_next = redirect_target;
               if (misaligned) state_next = ST_FAULT;
            end
         end
         ST_RUN: begin
            if (redirect_valid) begin
               flush   = 1'b1;
               pc_next = redirect_target;
               if (misaligned) state_next = ST_FAULT;
            end else if (has_room) begin
               if (bounds_fail) begin
                  state_next = ST_FAULT;
               end else begin
                  push    = 1'b1;
                  pc_next = pc + 32'd4;
               end
            end
         end
         ST_FAULT: begin
            flush = 1'b1;
         end
         default: begin
            state_next = ST_FAULT;
            flush      = 1'b1;
         end
      endcase
   end

   fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .count     (count),
      .head      (head)
   );

   assign imem_address = pc;
   assign out_valid    = (count != '0) && (state != ST_FAULT);
   assign out_instr    = out_valid ? head.instr : '0;
   assign out_pc       = out_valid ? head.pc : '0;
   assign fault        = (state == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] imem_address;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   assign imem_data = imem_address ^ 32'hA5A5_0000;

   instr_fetch_unit dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .imem_address    (imem_address),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .fault           (fault)
   );

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input logic ready);
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = ready;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic drain_scoreboard(input logic [31:0] start, input int n);
      logic [31:0] exp_pc;
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
      for (int i = 0; i < n; i++) begin
         exp_pc = exp_q.pop_front();
         tests_run++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== (exp_pc ^ 32'hA5A5_0000)) begin
            tests_failed++;
            $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, exp_pc, exp_pc ^ 32'hA5A5_0000);
         end
         step();
      end
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      tests_run++;
      if (out_valid !== 1'b0 || fault !== 1'b0 || imem_address !== 32'h8002_0000 ||
          out_pc !== 32'h0 || out_instr !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset: valid=%b fault=%b addr=%h pc=%h instr=%h, expected 0 0 80020000 0 0",
                  out_valid, fault, imem_address, out_pc, out_instr);
      end
   endtask

   task automatic test_stream();
      step();
      tests_run++;
      if (out_valid !== 1'b0 || imem_address !== 32'h8002_0000) begin
         tests_failed++;
         $display("FAIL bubble: valid=%b addr=%h, expected 0 80020000", out_valid, imem_address);
      end
      step();
      drain_scoreboard(32'h8002_0000, 3);
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      repeat (6) step();
      tests_run++;
      if (out_valid !== 1'b1 || imem_address !== 32'h8002_0008 || out_pc !== 32'h8002_0000) begin
         tests_failed++;
         $display("FAIL full_hold: valid=%b addr=%h pc=%h, expected 1 80020008 80020000",
                  out_valid, imem_address, out_pc);
      end
      out_ready = 1'b1;
      drain_scoreboard(32'h8002_0000, 5);
   endtask

   task automatic test_redirect();
      tests_run++;
      if (out_pc !== 32'h8002_0014 || imem_address !== 32'h8002_001C) begin
         tests_failed++;
         $display("FAIL pre_redirect: pc=%h addr=%h, expected 80020014 8002001c", out_pc, imem_address);
      end
      redirect_valid  = 1'b1;
      redirect_target = 32'h8002_0100;
      step();
      redirect_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || imem_address !== 32'h8002_0100) begin
         tests_failed++;
         $display("FAIL redirect_flush: valid=%b addr=%h, expected 0 80020100", out_valid, imem_address);
      end
      step();
      drain_scoreboard(32'h8002_0100, 3);
   endtask

   task automatic test_fault();
      redirect_valid  = 1'b1;
      redirect_target = 32'h8002_0102;
      step();
      tests_run++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_address !== 32'h8002_0102) begin
         tests_failed++;
         $display("FAIL misalign: fault=%b valid=%b addr=%h, expected 1 0 80020102", fault, out_valid, imem_address);
      end
      redirect_target = 32'h8002_0200;
      step();
      redirect_valid = 1'b0;
      step();
      tests_run++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_address !== 32'h8002_0102) begin
         tests_failed++;
         $display("FAIL fault_sticky: fault=%b valid=%b addr=%h, expected 1 0 80020102", fault, out_valid, imem_address);
      end
      reset_n = 1'b0;
      step();
      tests_run++;
      if (fault !== 1'b0 || out_valid !== 1'b0 || imem_address !== 32'h8002_0000) begin
         tests_failed++;
         $display("FAIL fault_reset: fault=%b valid=%b addr=%h, expected 0 0 80020000", fault, out_valid, imem_address);
      end
   endtask

   task automatic test_idle_redirect();
      do_reset(1'b1);
      redirect_valid  = 1'b1;
      redirect_target = 32'h8002_0040;
      step();
      redirect_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || imem_address !== 32'h8002_0040 || fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_redirect: valid=%b addr=%h fault=%b, expected 0 80020040 0", out_valid, imem_address, fault);
      end
      step();
      drain_scoreboard(32'h8002_0040, 3);
   endtask

`ifdef FETCH_BOUNDS_CHECK_EN
   task automatic test_bounds();
      do_reset(1'b1);
      redirect_valid  = 1'b1;
      redirect_target = 32'h8002_03F8;
      step();
      redirect_valid = 1'b0;
      step();
      drain_scoreboard(32'h8002_03F8, 2);
      tests_run++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_address !== 32'h8002_0400) begin
         tests_failed++;
         $display("FAIL bounds: fault=%b valid=%b addr=%h, expected 1 0 80020400", fault, out_valid, imem_address);
      end
   endtask
`else
   task automatic test_wrap();
      do_reset(1'b1);
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || imem_address !== 32'hFFFF_FFFC) begin
         tests_failed++;
         $display("FAIL wrap_redirect: valid=%b addr=%h, expected 0 fffffffc", out_valid, imem_address);
      end
      step();
      drain_scoreboard(32'hFFFF_FFFC, 3);
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_idle_redirect();
`ifdef FETCH_BOUNDS_CHECK_EN
      test_bounds();
`else
      test_wrap();
`endif
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
